// File: rtl/lifo_stack_pkg.sv
// Shared definitions for the LIFO stack: request encodings formed from {PUSH,POP}
// and the occupancy classes derived from the stack pointer.
package lifo_stack_pkg;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_SWAP = 2'b11;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_PART  = 2'd1,
    S_FULL  = 2'd2
  } occ_t;

  // Occupancy is never stored; it is always recomputed from the live count.
  function automatic occ_t occupancy(input int count, input int depth);
    if (count == 0)
      return S_EMPTY;
    else if (count >= depth)
      return S_FULL;
    else
      return S_PART;
  endfunction

endpackage

// File: rtl/sp_updown.sv
// Synchronous up/down counter used as the stack pointer; the caller is
// responsible for keeping it inside its legal range via EN.
module sp_updown #(
  parameter int N = 5
) (
  input  logic         CLK,
  input  logic         Clr,
  input  logic         EN,
  input  logic         UP,
  output logic [N-1:0] Q
);

  localparam logic [N-1:0] STEP = 1;

  always_ff @(posedge CLK) begin
    if (!Clr)
      Q <= '0;
    else if (EN)
      Q <= UP ? Q + STEP : Q - STEP;
  end

endmodule

// File: rtl/lifo_stack.sv
// LIFO stack: storage array, request decode and registered read port, with the
// occupancy held solely in the sp_updown pointer.
module lifo_stack
  import lifo_stack_pkg::*;
#(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          CLK,
  input  logic          Clr,
  input  logic          PUSH,
  input  logic          POP,
  input  logic [W-1:0]  DIN,
  output logic [W-1:0]  DOUT,
  output logic          VALID,
  output logic          FULL,
  output logic          EMPTY,
  output logic [AW:0]   COUNT,
  output logic          OVF,
  output logic          UNF
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] IDX_ONE = 1;

  logic [W-1:0]  mem [DEPTH];
  logic [1:0]    op;
  occ_t          occ;
  logic          spEn;
  logic          spUp;
  logic          memWe;
  logic [AW-1:0] memAddr;
  logic [AW-1:0] wrIdx;
  logic [AW-1:0] topIdx;

  assign op     = {PUSH, POP};
  assign occ    = occupancy(int'(COUNT), DEPTH);
  assign wrIdx  = COUNT[AW-1:0];
  assign topIdx = COUNT[AW-1:0] - IDX_ONE;
  assign FULL   = (occ == S_FULL);
  assign EMPTY  = (occ == S_EMPTY);

  // Pointer movement and write port; limits are enforced here, not in the counter.
  always_comb begin
    spEn    = 1'b0;
    spUp    = 1'b0;
    memWe   = 1'b0;
    memAddr = wrIdx;
    case (op)
      OP_PUSH: begin
        if (occ != S_FULL) begin
          spEn  = 1'b1;
          spUp  = 1'b1;
          memWe = 1'b1;
        end
      end
      OP_POP: begin
        if (occ != S_EMPTY)
          spEn = 1'b1;
      end
      OP_SWAP: begin
        if (occ != S_EMPTY) begin
          memWe   = 1'b1;
          memAddr = topIdx;
        end
      end
      default: ;
    endcase
  end

  sp_updown #(
    .N (AW + 1)
  ) u_sp (
    .CLK (CLK),
    .Clr (Clr),
    .EN  (spEn),
    .UP  (spUp),
    .Q   (COUNT)
  );

  // Storage is not cleared by reset, but a reset edge suppresses any write.
  always_ff @(posedge CLK) begin
    if (Clr && memWe)
      mem[memAddr] <= DIN;
  end

  // Read port samples the old top, so a swap returns the previous entry, not DIN.
  always_ff @(posedge CLK) begin
    if (!Clr) begin
      DOUT  <= '0;
      VALID <= 1'b0;
      OVF   <= 1'b0;
      UNF   <= 1'b0;
    end else begin
      VALID <= 1'b0;
      OVF   <= 1'b0;
      UNF   <= 1'b0;
      case (op)
        OP_PUSH: begin
          if (occ == S_FULL)
            OVF <= 1'b1;
        end
        OP_POP: begin
          if (occ == S_EMPTY) begin
            UNF <= 1'b1;
          end else begin
            DOUT  <= mem[topIdx];
            VALID <= 1'b1;
          end
        end
        OP_SWAP: begin
          DOUT  <= (occ == S_EMPTY) ? DIN : mem[topIdx];
          VALID <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/lifo_stack.md
Name: lifo_stack

Overview:
- Synchronous LIFO stack: data storage array plus pointer control, with push/pop, full/empty flags and a registered read port.
- The stack pointer is an up/down counter with clear and enable, instantiated as a sub-module.
- Downstream consumer of the pointer counter.
- Top-level building block for the stack half of the stack/queue design.

Parameters:
W, 8, data word width in bits
AW, 4, address width; DEPTH = 2**AW entries (default 16)

Ports:
CLK  input  1  system clock, all state updates on rising edge
Clr  input  1  synchronous active-low reset, sampled on rising CLK
PUSH  input  1  push request, DIN written this cycle if accepted
POP  input  1  pop request, top entry returned next cycle if accepted
DIN  input  W  data to push
DOUT  output  W  popped data, registered, held until next accepted pop
VALID  output  1  one-cycle pulse: DOUT updated by an accepted pop
FULL  output  1  COUNT == DEPTH
EMPTY  output  1  COUNT == 0
COUNT  output  AW+1  current occupancy, 0..DEPTH
OVF  output  1  one-cycle pulse: push rejected because full
UNF  output  1  one-cycle pulse: pop rejected because empty

Behaviour:
- Reset (Clr=0 at a rising edge):
  - COUNT=0, EMPTY=1, FULL=0, DOUT=0, VALID=0, OVF=0, UNF=0.
  - Storage contents are don't-care and are not cleared.
  - Reset overrides any PUSH/POP in the same cycle.
- Pointer: SP = COUNT. The top entry is at index SP-1 and the next write goes to index SP.
- Occupancy state is derived from COUNT, not stored separately: S_EMPTY (0), S_PART (1..DEPTH-1), S_FULL (DEPTH).
- Push only (PUSH=1, POP=0):
  - Not full: mem[SP] <= DIN, COUNT+1.
  - Full: no write, COUNT unchanged, OVF=1 for one cycle.
- Pop only (PUSH=0, POP=1):
  - Not empty: DOUT <= mem[SP-1], COUNT-1, VALID=1 next cycle (1-cycle latency).
  - Empty: DOUT unchanged, VALID=0, UNF=1 for one cycle.
- Push and pop together:
  - Not empty (includes full): swap. DOUT <= mem[SP-1], then mem[SP-1] <= DIN. COUNT unchanged, VALID=1, no OVF.
  - Empty: bypass. DOUT <= DIN, VALID=1, COUNT stays 0, no UNF.
- Read-before-write: in a swap, DOUT gets the old top, never DIN.
- Flag timing: FULL, EMPTY and COUNT are registered and reflect the state after the edge. OVF, UNF and VALID are registered pulses for the edge's operation.
- Arithmetic: COUNT is AW+1 bits and never wraps. Increment is gated at DEPTH and decrement at 0. Memory index uses SP[AW-1:0].
- Idle (neither request): all state held; VALID, OVF and UNF return to 0.
- Reset during a burst of operations: state is cleared at that edge and the next accepted push lands at index 0.

Decomposition:
- Shared package holds:
  - op encoding constants OP_NONE=2'b00, OP_POP=2'b01, OP_PUSH=2'b10, OP_SWAP=2'b11, formed from {PUSH,POP};
  - occupancy state constants S_EMPTY, S_PART, S_FULL.
- One sub-module, sp_updown: (AW+1)-bit synchronous up/down counter.
  - Inputs: CLK, Clr (active-low sync), EN, UP. Output: Q.
  - Limit gating is done in lifo_stack, which drives EN.
- Storage array, op decode and output registers live in lifo_stack.

Test Plan:
- Reset then idle 3 cycles -> COUNT=0, EMPTY=1, FULL=0, DOUT=0, VALID=0, OVF=0, UNF=0.
- Push 0x11, 0x22, 0x33, then pop 3 times -> DOUT=0x33, 0x22, 0x11 on successive cycles, VALID=1 each, final EMPTY=1, COUNT=0.
- Push 16 values 0x00..0x0F, then push 0xAA -> FULL=1, COUNT=16, OVF=1 for one cycle; the next pop returns 0x0F, not 0xAA.
- Pop when empty -> UNF=1, VALID=0, DOUT unchanged, COUNT stays 0. PUSH+POP with DIN=0x5C when empty -> DOUT=0x5C, VALID=1, COUNT=0, UNF=0.
- With 0x01, 0x02 stacked, PUSH+POP with DIN=0x99 -> DOUT=0x02, COUNT=2. Next pop -> DOUT=0x99. Next pop -> 0x01.
- Push 4 values, assert Clr=0 coincident with PUSH -> COUNT=0, EMPTY=1. Then push 0x77 and pop -> DOUT=0x77, EMPTY=1.
